// File: rtl/cache_control_nway_if.sv
// Control bundle between the N-way cache controller and its datapath/memory side.
// slave: controller view (metadata/requests in, array controls/stats out); master: the other side.
interface cache_control_nway_if #(
    parameter int WAYS  = 8,
    parameter int SETS  = 8,
    parameter int CNT_W = 32
);
    localparam int WAY_W = $clog2(WAYS);
    localparam int SET_W = $clog2(SETS);

    logic [WAYS-1:0]  cmp;
    logic [WAYS-1:0]  dirty;
    logic [WAYS-1:0]  valid;
    logic [WAY_W-1:0] lru;
    logic             mem_read;
    logic             mem_write;
    logic             flush;
    logic             cacheline_resp;

    logic [WAY_W-1:0] sel;
    logic [WAY_W-1:0] mru;
    logic             data_in_sel;
    logic [WAYS-1:0]  write_en;
    logic [WAYS-1:0]  load_tag;
    logic             load_lru;
    logic             load_dirty;
    logic             load_valid;
    logic [WAYS-1:0]  dirty_in;
    logic [WAYS-1:0]  valid_in;
    logic             flush_active;
    logic [SET_W-1:0] flush_set;
    logic             resp;
    logic             cacheline_read;
    logic             cacheline_write;
    logic [CNT_W-1:0] hit_count;
    logic [CNT_W-1:0] miss_count;

    modport slave (
        input  cmp, dirty, valid, lru, mem_read, mem_write, flush, cacheline_resp,
        output sel, mru, data_in_sel, write_en, load_tag, load_lru, load_dirty,
        output load_valid, dirty_in, valid_in, flush_active, flush_set, resp,
        output cacheline_read, cacheline_write, hit_count, miss_count
    );

    modport master (
        output cmp, dirty, valid, lru, mem_read, mem_write, flush, cacheline_resp,
        input  sel, mru, data_in_sel, write_en, load_tag, load_lru, load_dirty,
        input  load_valid, dirty_in, valid_in, flush_active, flush_set, resp,
        input  cacheline_read, cacheline_write, hit_count, miss_count
    );
endinterface

// File: rtl/cache_control_nway.sv
// N-way write-back/write-allocate set-associative cache controller with flush walk and stats.
// Ports: clk, rst (sync, active-high), bus (slave modport: metadata/requests in, array controls out).
module cache_control_nway #(
    parameter int WAYS  = 8,
    parameter int SETS  = 8,
    parameter int CNT_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    cache_control_nway_if.slave  bus
);
    localparam int WAY_W = $clog2(WAYS);
    localparam int SET_W = $clog2(SETS);

    typedef enum logic [3:0] {
        IDLE, HIT_WAIT, WRITE_BACK, META_UPDATE, READ_MEM, READ_END, WRITE_END,
        FLUSH_CHECK, FLUSH_WB, FLUSH_CLEAN, ADVANCE, FLUSH_DONE
    } state_t;

    state_t           state, state_n;
    logic [WAY_W-1:0] prev_lru;
    logic [WAY_W-1:0] flush_way, flush_way_n;
    logic [SET_W-1:0] flush_set, flush_set_n;
    logic [CNT_W-1:0] hit_count, miss_count;
    logic [WAYS-1:0]  hit_vec;
    logic [WAY_W-1:0] hit_way;
    logic             hit, req, fill;

    // Lowest set index wins, so a multi-hit vector still resolves deterministically.
    function automatic logic [WAY_W-1:0] enc(input logic [WAYS-1:0] v);
        enc = '0;
        for (int i = WAYS - 1; i >= 0; i--)
            if (v[i]) enc = WAY_W'(i);
    endfunction

    assign hit_vec = bus.cmp & bus.valid;
    assign hit     = |hit_vec;
    assign hit_way = enc(hit_vec);
    // Simultaneous read and write is not a legal request.
    assign req     = bus.mem_read ^ bus.mem_write;

    assign bus.flush_set  = flush_set;
    assign bus.hit_count  = hit_count;
    assign bus.miss_count = miss_count;

    always_comb begin
        state_n             = state;
        flush_way_n         = flush_way;
        flush_set_n         = flush_set;
        fill                = 1'b0;
        bus.sel             = hit_way;
        bus.mru             = hit_way;
        bus.data_in_sel     = 1'b0;
        bus.write_en        = '0;
        bus.load_tag        = '0;
        bus.load_lru        = 1'b0;
        bus.load_dirty      = 1'b0;
        bus.load_valid      = 1'b0;
        bus.dirty_in        = bus.dirty;
        bus.valid_in        = bus.valid;
        bus.flush_active    = 1'b0;
        bus.resp            = 1'b0;
        bus.cacheline_read  = 1'b0;
        bus.cacheline_write = 1'b0;
        unique case (state)
            IDLE: begin
                if (req && hit) begin
                    bus.resp     = 1'b1;
                    bus.load_lru = 1'b1;
                    if (bus.mem_write) begin
                        bus.write_en         = hit_vec;
                        bus.dirty_in[hit_way] = 1'b1;
                        bus.load_dirty       = 1'b1;
                    end
                    state_n = HIT_WAIT;
                end else if (req) begin
                    if (bus.dirty[bus.lru] && bus.valid[bus.lru]) begin
                        state_n = WRITE_BACK;
                    end else begin
                        fill    = 1'b1;
                        state_n = READ_MEM;
                    end
                end else if (bus.flush && !bus.mem_read && !bus.mem_write) begin
                    flush_set_n = '0;
                    flush_way_n = '0;
                    state_n     = FLUSH_CHECK;
                end
            end
            HIT_WAIT: state_n = IDLE;
            WRITE_BACK: begin
                bus.sel             = bus.lru;
                bus.cacheline_write = 1'b1;
                if (bus.cacheline_resp) state_n = META_UPDATE;
            end
            META_UPDATE: begin
                fill    = 1'b1;
                state_n = READ_MEM;
            end
            READ_MEM: begin
                bus.cacheline_read     = 1'b1;
                bus.data_in_sel        = 1'b1;
                bus.write_en[prev_lru] = 1'b1;
                if (bus.cacheline_resp)
                    state_n = bus.mem_write ? WRITE_END : READ_END;
            end
            READ_END: begin
                bus.resp = 1'b1;
                state_n  = IDLE;
            end
            WRITE_END: begin
                bus.resp     = 1'b1;
                bus.write_en = hit_vec;
                state_n      = IDLE;
            end
            FLUSH_CHECK: begin
                bus.flush_active = 1'b1;
                bus.sel          = flush_way;
                if (bus.dirty[flush_way] && bus.valid[flush_way]) state_n = FLUSH_WB;
                else state_n = ADVANCE;
            end
            FLUSH_WB: begin
                bus.flush_active    = 1'b1;
                bus.sel             = flush_way;
                bus.cacheline_write = 1'b1;
                if (bus.cacheline_resp) state_n = FLUSH_CLEAN;
            end
            FLUSH_CLEAN: begin
                bus.flush_active        = 1'b1;
                bus.dirty_in[flush_way] = 1'b0;
                bus.load_dirty          = 1'b1;
                state_n                 = ADVANCE;
            end
            ADVANCE: begin
                bus.flush_active = 1'b1;
                if (flush_way == WAY_W'(WAYS - 1) && flush_set == SET_W'(SETS - 1)) begin
                    state_n = FLUSH_DONE;
                end else begin
                    if (flush_way == WAY_W'(WAYS - 1)) begin
                        flush_way_n = '0;
                        flush_set_n = flush_set + SET_W'(1);
                    end else begin
                        flush_way_n = flush_way + WAY_W'(1);
                    end
                    state_n = FLUSH_CHECK;
                end
            end
            FLUSH_DONE: begin
                bus.flush_active = 1'b1;
                bus.resp         = 1'b1;
                state_n          = IDLE;
            end
            default: state_n = IDLE;
        endcase
        // Victim allocation: shared by the clean-miss IDLE cycle and META_UPDATE.
        if (fill) begin
            bus.mru              = bus.lru;
            bus.load_lru         = 1'b1;
            bus.load_dirty       = 1'b1;
            bus.load_valid       = 1'b1;
            bus.load_tag[bus.lru] = 1'b1;
            bus.valid_in[bus.lru] = 1'b1;
            bus.dirty_in[bus.lru] = bus.mem_write;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            prev_lru   <= '0;
            flush_set  <= '0;
            flush_way  <= '0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            state     <= state_n;
            flush_set <= flush_set_n;
            flush_way <= flush_way_n;
            if (bus.load_lru) prev_lru <= bus.lru;
            if (state == IDLE && req && hit && hit_count != '1)
                hit_count <= hit_count + CNT_W'(1);
            if (state == IDLE && req && !hit && miss_count != '1)
                miss_count <= miss_count + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_cache_control_nway.sv
// Self-checking bench for cache_control_nway: 8-way/4-bit-counter instance for request paths,
// 2-way/4-set instance for the flush walk.
module tb_cache_control_nway;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cache_control_nway_if #(.WAYS(8), .SETS(8), .CNT_W(4)) a_if();
    cache_control_nway_if #(.WAYS(2), .SETS(4), .CNT_W(32)) b_if();

    cache_control_nway #(.WAYS(8), .SETS(8), .CNT_W(4)) u_a (
        .clk(clk), .rst(rst), .bus(a_if.slave));
    cache_control_nway #(.WAYS(2), .SETS(4), .CNT_W(32)) u_b (
        .clk(clk), .rst(rst), .bus(b_if.slave));

    int checks   = 0;
    int failures = 0;
    int exp_q[$];
    int exp_hits   = 0;
    int exp_misses = 0;

    // Metadata model for the flush instance: only set 1 / way 1 starts dirty+valid.
    logic [1:0] b_dirty_arr[4];
    logic [1:0] b_valid_arr[4];
    assign b_if.dirty = b_dirty_arr[b_if.flush_set];
    assign b_if.valid = b_valid_arr[b_if.flush_set];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                b_dirty_arr[i] <= (i == 1) ? 2'b10 : 2'b00;
                b_valid_arr[i] <= (i == 1) ? 2'b10 : 2'b00;
            end
        end else begin
            if (b_if.load_dirty) b_dirty_arr[b_if.flush_set] <= b_if.dirty_in;
            if (b_if.load_valid) b_valid_arr[b_if.flush_set] <= b_if.valid_in;
        end
    end

    task automatic a_idle();
        a_if.mem_read = 0; a_if.mem_write = 0; a_if.flush = 0;
        a_if.cacheline_resp = 0;
    endtask

    task automatic test_reset();
        a_idle();
        a_if.cmp = 8'h00; a_if.dirty = 8'h05; a_if.valid = 8'h0F; a_if.lru = 3'd0;
        b_if.cmp = 2'b00; b_if.lru = 1'b0; b_if.mem_read = 0; b_if.mem_write = 0;
        b_if.flush = 0; b_if.cacheline_resp = 0;
        rst = 1;
        @(negedge clk); @(negedge clk);
        rst = 0;
        #1;
        checks++; if (a_if.resp !== 1'b0) begin failures++; $display("FAIL rst_resp got=%0h exp=0", a_if.resp); end
        checks++; if ({a_if.load_lru, a_if.load_dirty, a_if.load_valid} !== 3'b000) begin failures++; $display("FAIL rst_loads got=%0h exp=0", {a_if.load_lru, a_if.load_dirty, a_if.load_valid}); end
        checks++; if (a_if.write_en !== 8'h00 || a_if.load_tag !== 8'h00) begin failures++; $display("FAIL rst_we got=%0h/%0h exp=0", a_if.write_en, a_if.load_tag); end
        checks++; if ({a_if.cacheline_read, a_if.cacheline_write, a_if.flush_active} !== 3'b000) begin failures++; $display("FAIL rst_cl got=%0h exp=0", {a_if.cacheline_read, a_if.cacheline_write, a_if.flush_active}); end
        checks++; if (a_if.dirty_in !== 8'h05 || a_if.valid_in !== 8'h0F) begin failures++; $display("FAIL rst_pass got=%0h/%0h exp=05/0f", a_if.dirty_in, a_if.valid_in); end
        checks++; if (a_if.hit_count !== 4'd0 || a_if.miss_count !== 4'd0 || a_if.flush_set !== 3'd0) begin failures++; $display("FAIL rst_cnt got=%0h/%0h/%0h exp=0", a_if.hit_count, a_if.miss_count, a_if.flush_set); end
    endtask

    task automatic test_read_hit();
        @(negedge clk);
        a_if.mem_read = 1; a_if.cmp = 8'h04; a_if.valid = 8'h04;
        #1;
        checks++; if (a_if.resp !== 1'b1 || a_if.load_lru !== 1'b1) begin failures++; $display("FAIL rh_resp got=%0b%0b exp=11", a_if.resp, a_if.load_lru); end
        checks++; if (a_if.sel !== 3'd2 || a_if.mru !== 3'd2) begin failures++; $display("FAIL rh_sel got=%0d/%0d exp=2", a_if.sel, a_if.mru); end
        exp_hits++; exp_q.push_back(exp_hits);
        @(negedge clk); #1;
        checks++; if (a_if.resp !== 1'b0) begin failures++; $display("FAIL rh_dead got=%0b exp=0", a_if.resp); end
        checks++; if (int'(a_if.hit_count) !== exp_q.pop_front()) begin failures++; $display("FAIL rh_cnt got=%0d exp=%0d", a_if.hit_count, exp_hits); end
        @(negedge clk); #1;
        checks++; if (a_if.resp !== 1'b1) begin failures++; $display("FAIL rh_again got=%0b exp=1", a_if.resp); end
        exp_hits++;
        @(negedge clk);
        a_idle();
        @(negedge clk); #1;
        checks++; if (int'(a_if.hit_count) !== exp_hits) begin failures++; $display("FAIL rh_cnt2 got=%0d exp=%0d", a_if.hit_count, exp_hits); end
    endtask

    task automatic test_write_hit();
        @(negedge clk);
        a_if.mem_write = 1; a_if.cmp = 8'h10; a_if.valid = 8'hFF; a_if.dirty = 8'h00;
        #1;
        checks++; if (a_if.write_en !== 8'h10) begin failures++; $display("FAIL wh_we got=%0h exp=10", a_if.write_en); end
        checks++; if (a_if.dirty_in !== 8'h10 || a_if.load_dirty !== 1'b1) begin failures++; $display("FAIL wh_dirty got=%0h/%0b exp=10/1", a_if.dirty_in, a_if.load_dirty); end
        checks++; if (a_if.resp !== 1'b1 || a_if.sel !== 3'd4) begin failures++; $display("FAIL wh_resp got=%0b/%0d exp=1/4", a_if.resp, a_if.sel); end
        exp_hits++;
        @(negedge clk);
        a_idle();
        @(negedge clk); #1;
        checks++; if (int'(a_if.hit_count) !== exp_hits) begin failures++; $display("FAIL wh_cnt got=%0d exp=%0d", a_if.hit_count, exp_hits); end
    endtask

    task automatic test_dirty_miss();
        bit got;
        @(negedge clk);
        a_if.mem_read = 1; a_if.cmp = 8'h00; a_if.valid = 8'hFF; a_if.dirty = 8'h20; a_if.lru = 3'd5;
        #1;
        checks++; if (a_if.resp !== 1'b0 || a_if.load_tag !== 8'h00) begin failures++; $display("FAIL dm_idle got=%0b/%0h exp=0/0", a_if.resp, a_if.load_tag); end
        exp_misses++; exp_q.push_back(exp_misses);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            a_if.cacheline_resp = (i == 7);
            #1;
            checks++; if (a_if.cacheline_write !== 1'b1 || a_if.sel !== 3'd5) begin failures++; $display("FAIL dm_wb%0d got=%0b/%0d exp=1/5", i, a_if.cacheline_write, a_if.sel); end
        end
        @(negedge clk);
        a_if.cacheline_resp = 0;
        #1;
        checks++; if (a_if.load_tag !== 8'h20 || a_if.mru !== 3'd5 || a_if.load_lru !== 1'b1) begin failures++; $display("FAIL dm_meta got=%0h/%0d/%0b exp=20/5/1", a_if.load_tag, a_if.mru, a_if.load_lru); end
        checks++; if (a_if.dirty_in !== 8'h00 || a_if.valid_in !== 8'hFF || a_if.cacheline_write !== 1'b0) begin failures++; $display("FAIL dm_meta2 got=%0h/%0h/%0b exp=00/ff/0", a_if.dirty_in, a_if.valid_in, a_if.cacheline_write); end
        @(negedge clk); #1;
        checks++; if (a_if.cacheline_read !== 1'b1 || a_if.data_in_sel !== 1'b1 || a_if.write_en !== 8'h20) begin failures++; $display("FAIL dm_rd got=%0b/%0b/%0h exp=1/1/20", a_if.cacheline_read, a_if.data_in_sel, a_if.write_en); end
        @(negedge clk);
        a_if.cacheline_resp = 1;
        @(negedge clk);
        a_if.cacheline_resp = 0;
        got = 0;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (a_if.resp === 1'b1) begin got = 1; break; end
            @(negedge clk);
        end
        checks++; if (!got) begin failures++; $display("FAIL dm_timeout got=no_resp exp=resp"); end
        checks++; if (int'(a_if.miss_count) !== exp_q.pop_front()) begin failures++; $display("FAIL dm_cnt got=%0d exp=%0d", a_if.miss_count, exp_misses); end
        @(negedge clk);
        a_idle();
    endtask

    task automatic test_clean_write_miss();
        bit got;
        @(negedge clk);
        a_if.mem_write = 1; a_if.cmp = 8'h00; a_if.valid = 8'hF7; a_if.dirty = 8'h00; a_if.lru = 3'd3;
        #1;
        checks++; if (a_if.load_tag !== 8'h08 || a_if.mru !== 3'd3) begin failures++; $display("FAIL wm_tag got=%0h/%0d exp=08/3", a_if.load_tag, a_if.mru); end
        checks++; if (a_if.dirty_in !== 8'h08 || a_if.valid_in !== 8'hFF) begin failures++; $display("FAIL wm_meta got=%0h/%0h exp=08/ff", a_if.dirty_in, a_if.valid_in); end
        checks++; if ({a_if.load_lru, a_if.load_dirty, a_if.load_valid, a_if.resp} !== 4'b1110) begin failures++; $display("FAIL wm_loads got=%0b exp=1110", {a_if.load_lru, a_if.load_dirty, a_if.load_valid, a_if.resp}); end
        exp_misses++; exp_q.push_back(exp_misses);
        @(negedge clk); #1;
        checks++; if (a_if.write_en !== 8'h08 || a_if.cacheline_read !== 1'b1) begin failures++; $display("FAIL wm_rd got=%0h/%0b exp=08/1", a_if.write_en, a_if.cacheline_read); end
        @(negedge clk);
        a_if.cacheline_resp = 1;
        @(negedge clk);
        a_if.cacheline_resp = 0; a_if.cmp = 8'h08; a_if.valid = 8'hFF;
        got = 0;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (a_if.resp === 1'b1) begin got = 1; break; end
            @(negedge clk);
        end
        checks++; if (!got) begin failures++; $display("FAIL wm_timeout got=no_resp exp=resp"); end
        checks++; if (a_if.write_en !== 8'h08) begin failures++; $display("FAIL wm_we got=%0h exp=08", a_if.write_en); end
        checks++; if (int'(a_if.miss_count) !== exp_q.pop_front()) begin failures++; $display("FAIL wm_cnt got=%0d exp=%0d", a_if.miss_count, exp_misses); end
        @(negedge clk);
        a_idle();
    endtask

    task automatic test_both_req();
        @(negedge clk);
        a_if.mem_read = 1; a_if.mem_write = 1; a_if.cmp = 8'h01; a_if.valid = 8'h01;
        #1;
        checks++; if (a_if.resp !== 1'b0 || a_if.load_lru !== 1'b0 || a_if.write_en !== 8'h00) begin failures++; $display("FAIL both_out got=%0b/%0b/%0h exp=0/0/0", a_if.resp, a_if.load_lru, a_if.write_en); end
        @(negedge clk);
        a_idle();
        #1;
        checks++; if (int'(a_if.hit_count) !== exp_hits || int'(a_if.miss_count) !== exp_misses) begin failures++; $display("FAIL both_cnt got=%0d/%0d exp=%0d/%0d", a_if.hit_count, a_if.miss_count, exp_hits, exp_misses); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        a_if.mem_read = 1; a_if.cmp = 8'h00; a_if.valid = 8'hFF; a_if.dirty = 8'h00; a_if.lru = 3'd1;
        @(negedge clk); #1;
        checks++; if (a_if.cacheline_read !== 1'b1) begin failures++; $display("FAIL rm_rd got=%0b exp=1", a_if.cacheline_read); end
        @(negedge clk);
        rst = 1; a_idle();
        @(negedge clk);
        rst = 0;
        exp_hits = 0; exp_misses = 0; exp_q.delete();
        #1;
        checks++; if (a_if.cacheline_read !== 1'b0 || a_if.resp !== 1'b0) begin failures++; $display("FAIL rm_idle got=%0b/%0b exp=0/0", a_if.cacheline_read, a_if.resp); end
        checks++; if (a_if.hit_count !== 4'd0 || a_if.miss_count !== 4'd0) begin failures++; $display("FAIL rm_cnt got=%0d/%0d exp=0/0", a_if.hit_count, a_if.miss_count); end
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            a_if.mem_read = 1; a_if.cmp = 8'h80; a_if.valid = 8'h80;
            if (exp_hits < 15) exp_hits++;
            @(negedge clk);
            a_idle();
        end
        @(negedge clk); #1;
        checks++; if (int'(a_if.hit_count) !== exp_hits || exp_hits != 15) begin failures++; $display("FAIL sat_cnt got=%0d exp=15", a_if.hit_count); end
        checks++; if (a_if.miss_count !== 4'd0) begin failures++; $display("FAIL sat_miss got=%0d exp=0", a_if.miss_count); end
    endtask

    task automatic test_flush();
        int  n_act, bursts, wb_cyc, cleans, bad, resp_cyc;
        bit  prev_cw, wb_ok, clean_ok, got;
        n_act = 0; bursts = 0; wb_cyc = 0; cleans = 0; bad = 0; resp_cyc = 0;
        prev_cw = 0; wb_ok = 1; clean_ok = 1; got = 0;
        @(negedge clk);
        b_if.flush = 1;
        #1;
        checks++; if (b_if.flush_active !== 1'b0 || b_if.resp !== 1'b0) begin failures++; $display("FAIL fl_idle got=%0b/%0b exp=0/0", b_if.flush_active, b_if.resp); end
        exp_q.push_back(21);
        @(negedge clk);
        b_if.flush = 0;
        for (int n = 1; n <= 60; n++) begin
            b_if.cacheline_resp = (wb_cyc == 2);
            #1;
            if (b_if.flush_active === 1'b1) n_act++;
            if (b_if.cacheline_write === 1'b1) begin
                if (!prev_cw) bursts++;
                wb_cyc++;
                if (b_if.flush_set !== 2'd1 || b_if.sel !== 1'b1) wb_ok = 0;
            end
            prev_cw = (b_if.cacheline_write === 1'b1);
            if (b_if.load_dirty === 1'b1) begin
                cleans++;
                if (b_if.flush_set !== 2'd1 || b_if.dirty_in !== 2'b00) clean_ok = 0;
            end
            if (b_if.load_valid === 1'b1 || b_if.load_lru === 1'b1 || b_if.cacheline_read === 1'b1) bad++;
            if (b_if.resp === 1'b1) begin resp_cyc = n; got = 1; break; end
            @(negedge clk);
        end
        checks++; if (!got) begin failures++; $display("FAIL fl_timeout got=no_resp exp=resp"); end
        checks++; if (resp_cyc !== exp_q.pop_front()) begin failures++; $display("FAIL fl_resp_cyc got=%0d exp=21", resp_cyc); end
        checks++; if (n_act !== 21) begin failures++; $display("FAIL fl_active got=%0d exp=21", n_act); end
        checks++; if (bursts !== 1 || !wb_ok) begin failures++; $display("FAIL fl_wb got=%0d/%0b exp=1/1", bursts, wb_ok); end
        checks++; if (cleans !== 1 || !clean_ok) begin failures++; $display("FAIL fl_clean got=%0d/%0b exp=1/1", cleans, clean_ok); end
        checks++; if (bad !== 0) begin failures++; $display("FAIL fl_touch got=%0d exp=0", bad); end
        checks++; if (b_if.flush_set !== 2'd3) begin failures++; $display("FAIL fl_set got=%0d exp=3", b_if.flush_set); end
        @(negedge clk);
        b_if.cacheline_resp = 0;
        #1;
        checks++; if (b_if.flush_active !== 1'b0 || b_if.resp !== 1'b0) begin failures++; $display("FAIL fl_end got=%0b/%0b exp=0/0", b_if.flush_active, b_if.resp); end
        checks++; if (b_dirty_arr[1] !== 2'b00 || b_valid_arr[1] !== 2'b10) begin failures++; $display("FAIL fl_meta got=%0b/%0b exp=00/10", b_dirty_arr[1], b_valid_arr[1]); end
        checks++; if (b_if.hit_count !== 32'd0 || b_if.miss_count !== 32'd0) begin failures++; $display("FAIL fl_cnt got=%0d/%0d exp=0/0", b_if.hit_count, b_if.miss_count); end
    endtask

    initial begin
        test_reset();
        test_read_hit();
        test_write_hit();
        test_dirty_miss();
        test_clean_write_miss();
        test_both_req();
        test_reset_mid();
        test_saturate();
        test_flush();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
